btn_debounce_bank: RTL

- Parametrised input conditioner for board push-buttons and switches feeding the CPU top-level I/O.
- Per channel, in order: synchroniser, stability-counter debouncer, edge detector, toggle latch and sticky event flag.
- Gives the CPU clean levels, one-cycle edge pulses and software-clearable pending bits.
- Replaces direct use of raw btn_u/btn_d/btn_l/btn_r and switches.

---
 rtl/io_pkg.sv | 15 +
 rtl/btn_debounce_bank_if.sv | 27 ++
 rtl/debounce_ch.sv | 80 ++++++++
 rtl/btn_debounce_bank.sv | 55 +++++
 4 files changed

// File: rtl/io_pkg.sv
// Board I/O constants shared by the input conditioner and the CPU top level.
package io_pkg;

  localparam int N_BTN         = 4;
  localparam int DB_CYCLES_HW  = 16;
  localparam int DB_CYCLES_SIM = 4;
  localparam int SYNC_STAGES_D = 2;

  // Channel positions of the four push-buttons within raw_in and every output vector.
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

endpackage

// File: rtl/btn_debounce_bank_if.sv
// Signal bundle between the board inputs / CPU and the debounce bank.
interface btn_debounce_bank_if
  import io_pkg::*;
#(
  parameter int N_CH = N_BTN
);

  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] evt_clr;
  logic [N_CH-1:0] db_level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] tgl;
  logic [N_CH-1:0] evt_pending;
  logic            any_pending;

  modport master (
    output raw_in, evt_clr,
    input  db_level, rise, fall, tgl, evt_pending, any_pending
  );

  modport slave (
    input  raw_in, evt_clr,
    output db_level, rise, fall, tgl, evt_pending, any_pending
  );

endinterface

// File: rtl/debounce_ch.sv
// One input channel: synchroniser, stability counter, edge pulses, toggle latch
// and software-clearable pending flag. Every output is a flop.
module debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_evt_clr,
  output logic o_db_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_tgl,
  output logic o_evt_pending
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_tgl;
  logic                   r_pend;

  logic w_sync;
  logic w_differs;
  logic w_accept;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = w_sync ^ r_level;
  assign w_accept  = w_differs && (r_cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_tgl   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};

      // Any sample that agrees with the accepted level restarts the count.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_rise <= w_accept & w_sync;
      r_fall <= w_accept & ~w_sync;

      if (w_accept && w_sync) begin
        r_tgl <= ~r_tgl;
      end

      // A new rise beats a simultaneous clear so no event is dropped.
      if (w_accept && w_sync) begin
        r_pend <= 1'b1;
      end else if (i_evt_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_db_level    = r_level;
  assign o_rise        = r_rise;
  assign o_fall        = r_fall;
  assign o_tgl         = r_tgl;
  assign o_evt_pending = r_pend;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of independent debounce channels plus a registered "anything pending" summary
// bit for the CPU interrupt / poll path.
module btn_debounce_bank
  import io_pkg::*;
#(
  parameter int N_CH        = N_BTN,
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DB_CYCLES   = DB_CYCLES_HW
) (
  input logic                clk,
  input logic                reset,
  btn_debounce_bank_if.slave bus
);

  logic [N_CH-1:0] w_db_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_tgl;
  logic [N_CH-1:0] w_pend;
  logic            r_any_pending;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_raw         (bus.raw_in[g]),
      .i_evt_clr     (bus.evt_clr[g]),
      .o_db_level    (w_db_level[g]),
      .o_rise        (w_rise[g]),
      .o_fall        (w_fall[g]),
      .o_tgl         (w_tgl[g]),
      .o_evt_pending (w_pend[g])
    );
  end

  // Registered so the summary bit never depends combinationally on a channel flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_pending <= 1'b0;
    end else begin
      r_any_pending <= |w_pend;
    end
  end

  assign bus.db_level    = w_db_level;
  assign bus.rise        = w_rise;
  assign bus.fall        = w_fall;
  assign bus.tgl         = w_tgl;
  assign bus.evt_pending = w_pend;
  assign bus.any_pending = r_any_pending;

endmodule
